// File: rtl/shift_arbiter_if.sv
// Request/result bundle between the two requesters, the result consumer and shift_arbiter.
// master drives requests and result ready; slave is the arbiter side.
interface shift_arbiter_if;
  localparam int unsigned W  = 16;
  localparam int unsigned SW = 4;

  logic          req0_valid;
  logic          req0_ready;
  logic [W-1:0]  req0_data;
  logic [SW-1:0] req0_shamt;
  logic [1:0]    req0_op;

  logic          req1_valid;
  logic          req1_ready;
  logic [W-1:0]  req1_data;
  logic [SW-1:0] req1_shamt;
  logic [1:0]    req1_op;

  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic          res_id;

  modport master (
    output req0_valid, req0_data, req0_shamt, req0_op,
    output req1_valid, req1_data, req1_shamt, req1_op,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id
  );

  modport slave (
    input  req0_valid, req0_data, req0_shamt, req0_op,
    input  req1_valid, req1_data, req1_shamt, req1_op,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter for two requesters sharing a 16-bit shift/rotate unit.
// Two stages: registered operands (S1), rotate+mask, registered result (S2).
module shift_arbiter (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  shift_arbiter_if.slave  bus,
  output logic            busy
);
  localparam int unsigned W  = 16;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {
    OP_ROR = 2'b00,
    OP_SLL = 2'b01,
    OP_SRL = 2'b10,
    OP_SRA = 2'b11
  } op_e;

  logic          s1_valid;
  logic [W-1:0]  s1_data;
  logic [SW-1:0] s1_shamt;
  op_e           s1_op;
  logic          s1_id;

  logic          s2_valid;
  logic [W-1:0]  s2_data;
  logic          s2_id;

  logic          prio;

  logic          gnt0, gnt1;
  logic          s2_load, s1_free;
  logic          acc0, acc1, acc;

  logic [SW-1:0]  rot_amt;
  logic [2*W-1:0] dbl;
  logic [W-1:0]   rot, hi_mask, lo_mask, shift_res;

  // prio=0 favours port 0 when both ports are valid
  always_comb begin
    gnt0    = bus.req0_valid & (~bus.req1_valid | ~prio);
    gnt1    = bus.req1_valid & (~bus.req0_valid | prio);
    s2_load = s1_valid & (~s2_valid | bus.res_ready);
    s1_free = ~s1_valid | s2_load;
  end

  assign bus.req0_ready = gnt0 & s1_free & ~flush;
  assign bus.req1_ready = gnt1 & s1_free & ~flush;

  assign acc0 = bus.req0_valid & bus.req0_ready;
  assign acc1 = bus.req1_valid & bus.req1_ready;
  assign acc  = acc0 | acc1;

  // All ops share one right-rotate; SLL rotates by (16-n) mod 16 instead
  always_comb begin
    rot_amt   = s1_shamt;
    if (s1_op == OP_SLL) begin
      rot_amt = SW'(W - 32'(s1_shamt));
    end
    dbl       = {s1_data, s1_data} >> rot_amt;
    rot       = dbl[W-1:0];
    hi_mask   = ~({W{1'b1}} >> s1_shamt);
    lo_mask   = ~({W{1'b1}} << s1_shamt);
    shift_res = rot;
    case (s1_op)
      OP_ROR:  shift_res = rot;
      OP_SLL:  shift_res = rot & ~lo_mask;
      OP_SRL:  shift_res = rot & ~hi_mask;
      OP_SRA:  shift_res = s1_data[W-1] ? (rot | hi_mask) : (rot & ~hi_mask);
      default: shift_res = rot;
    endcase
  end

  // Operand stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_shamt <= '0;
      s1_op    <= OP_ROR;
      s1_id    <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (acc) begin
      s1_valid <= 1'b1;
      s1_data  <= acc1 ? bus.req1_data  : bus.req0_data;
      s1_shamt <= acc1 ? bus.req1_shamt : bus.req0_shamt;
      s1_op    <= op_e'(acc1 ? bus.req1_op : bus.req0_op);
      s1_id    <= acc1;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Result stage; data/id only change on a load so they hold under back-pressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_id    <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_data  <= shift_res;
      s2_id    <= s1_id;
    end else if (bus.res_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // After an accept the other port gets priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (acc) begin
      prio <= acc0;
    end
  end

  assign bus.res_valid = s2_valid;
  assign bus.res_data  = s2_data;
  assign bus.res_id    = s2_id;
  assign busy          = s1_valid | s2_valid;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter: ops, contention, back-pressure, flush, reset.
module tb_shift_arbiter;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;

  shift_arbiter_if ifc ();

  shift_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (ifc),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit port, input logic v, input logic [15:0] d,
                       input logic [3:0] s, input logic [1:0] op);
    if (port) begin
      ifc.req1_valid = v; ifc.req1_data = d; ifc.req1_shamt = s; ifc.req1_op = op;
    end else begin
      ifc.req0_valid = v; ifc.req0_data = d; ifc.req0_shamt = s; ifc.req0_op = op;
    end
  endtask

  // Single op from idle with res_ready=1: accept, one cycle in S1, result, drained
  task automatic run_op(input string tag, input bit port, input logic [15:0] d,
                        input logic [3:0] s, input logic [1:0] op, input logic [15:0] exp);
    drive(port, 1'b1, d, s, op);
    #1;
    check({tag, "_ready"}, 32'(port ? ifc.req1_ready : ifc.req0_ready), 32'd1);
    tick();
    drive(port, 1'b0, 16'h0, 4'h0, 2'b00);
    check({tag, "_early"}, 32'(ifc.res_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    tick();
    check({tag, "_valid"}, 32'(ifc.res_valid), 32'd1);
    check({tag, "_data"}, 32'(ifc.res_data), 32'(exp));
    check({tag, "_id"}, 32'(ifc.res_id), 32'(port));
    tick();
    check({tag, "_drained"}, 32'(ifc.res_valid), 32'd0);
  endtask

  function automatic logic [15:0] cont_exp(input int i);
    return ((i % 2) != 0 ? 16'h0B00 : 16'h0A00) + 16'(i / 2);
  endfunction

  initial begin
    ifc.req0_valid = 1'b0; ifc.req0_data = '0; ifc.req0_shamt = '0; ifc.req0_op = '0;
    ifc.req1_valid = 1'b0; ifc.req1_data = '0; ifc.req1_shamt = '0; ifc.req1_op = '0;
    ifc.res_ready  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_res_valid", 32'(ifc.res_valid), 32'd0);
    check("rst_res_data", 32'(ifc.res_data), 32'h0000);
    check("rst_res_id", 32'(ifc.res_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("ror_p0", 1'b0, 16'h1234, 4'd4, 2'b00, 16'h4123);
    run_op("sll_p1", 1'b1, 16'h8001, 4'd1, 2'b01, 16'h0002);
    run_op("srl_p1", 1'b1, 16'h8000, 4'd15, 2'b10, 16'h0001);
    run_op("sra_neg_p1", 1'b1, 16'h8000, 4'd15, 2'b11, 16'hFFFF);
    run_op("sra_pos_p1", 1'b1, 16'h7FF0, 4'd4, 2'b11, 16'h07FF);
    run_op("ror0_p1", 1'b1, 16'hA5C3, 4'd0, 2'b00, 16'hA5C3);
    run_op("sll0_p1", 1'b1, 16'hA5C3, 4'd0, 2'b01, 16'hA5C3);
    run_op("srl0_p1", 1'b1, 16'hA5C3, 4'd0, 2'b10, 16'hA5C3);
    run_op("sra0_p1", 1'b1, 16'hA5C3, 4'd0, 2'b11, 16'hA5C3);

    // Contention: grants alternate starting at port 0
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b1, 16'h0A00 + 16'(c / 2), 4'd0, 2'b00);
      drive(1'b1, 1'b1, 16'h0B00 + 16'(c / 2), 4'd0, 2'b00);
      #1;
      check($sformatf("cont_gnt0_c%0d", c), 32'(ifc.req0_ready), 32'((c % 2) == 0));
      check($sformatf("cont_gnt1_c%0d", c), 32'(ifc.req1_ready), 32'((c % 2) == 1));
      tick();
      if (c >= 1) begin
        check($sformatf("cont_valid_%0d", c - 1), 32'(ifc.res_valid), 32'd1);
        check($sformatf("cont_data_%0d", c - 1), 32'(ifc.res_data), 32'(cont_exp(c - 1)));
        check($sformatf("cont_id_%0d", c - 1), 32'(ifc.res_id), 32'((c - 1) % 2));
      end
    end
    drive(1'b0, 1'b0, 16'h0, 4'h0, 2'b00);
    drive(1'b1, 1'b0, 16'h0, 4'h0, 2'b00);
    tick();
    check("cont_data_5", 32'(ifc.res_data), 32'(cont_exp(5)));
    check("cont_id_5", 32'(ifc.res_id), 32'd1);
    tick();
    check("cont_idle", 32'(ifc.res_valid), 32'd0);

    // Back-pressure: two accepted, then stall with stable output
    ifc.res_ready = 1'b0;
    drive(1'b0, 1'b1, 16'hC000, 4'd0, 2'b00);
    #1;
    check("bp_rdy_a", 32'(ifc.req0_ready), 32'd1);
    tick();
    drive(1'b0, 1'b1, 16'hC001, 4'd0, 2'b00);
    #1;
    check("bp_rdy_b", 32'(ifc.req0_ready), 32'd1);
    tick();
    drive(1'b0, 1'b1, 16'hC002, 4'd0, 2'b00);
    #1;
    check("bp_rdy_full", 32'(ifc.req0_ready), 32'd0);
    check("bp_valid", 32'(ifc.res_valid), 32'd1);
    check("bp_data", 32'(ifc.res_data), 32'hC000);
    tick();
    check("bp_rdy_still", 32'(ifc.req0_ready), 32'd0);
    check("bp_data_stable", 32'(ifc.res_data), 32'hC000);
    check("bp_busy", 32'(busy), 32'd1);
    ifc.res_ready = 1'b1;
    #1;
    check("bp_rdy_release", 32'(ifc.req0_ready), 32'd1);
    tick();
    drive(1'b0, 1'b0, 16'h0, 4'h0, 2'b00);
    check("bp_drain1", 32'(ifc.res_data), 32'hC001);
    check("bp_drain1_v", 32'(ifc.res_valid), 32'd1);
    tick();
    check("bp_drain2", 32'(ifc.res_data), 32'hC002);
    check("bp_drain2_v", 32'(ifc.res_valid), 32'd1);
    tick();
    check("bp_empty", 32'(ifc.res_valid), 32'd0);
    check("bp_empty_busy", 32'(busy), 32'd0);

    // Flush with both stages occupied
    ifc.res_ready = 1'b0;
    drive(1'b0, 1'b1, 16'hD000, 4'd0, 2'b00);
    tick();
    drive(1'b0, 1'b1, 16'hD001, 4'd0, 2'b00);
    tick();
    drive(1'b0, 1'b1, 16'hD002, 4'd0, 2'b00);
    ifc.res_ready = 1'b1;
    flush = 1'b1;
    #1;
    check("fl_rdy_masked", 32'(ifc.req0_ready), 32'd0);
    check("fl_res_valid_in", 32'(ifc.res_valid), 32'd1);
    tick();
    flush = 1'b0;
    check("fl_res_valid", 32'(ifc.res_valid), 32'd0);
    check("fl_busy", 32'(busy), 32'd0);
    #1;
    check("fl_next_rdy", 32'(ifc.req0_ready), 32'd1);
    tick();
    drive(1'b0, 1'b0, 16'h0, 4'h0, 2'b00);
    check("fl_no_ghost", 32'(ifc.res_valid), 32'd0);
    tick();
    check("fl_next_valid", 32'(ifc.res_valid), 32'd1);
    check("fl_next_data", 32'(ifc.res_data), 32'hD002);
    tick();
    check("fl_next_drained", 32'(ifc.res_valid), 32'd0);

    // Async reset with both stages full; prio left pointing at port 1
    ifc.res_ready = 1'b0;
    drive(1'b0, 1'b1, 16'hE000, 4'd0, 2'b00);
    tick();
    drive(1'b0, 1'b1, 16'hE001, 4'd0, 2'b00);
    tick();
    drive(1'b0, 1'b0, 16'h0, 4'h0, 2'b00);
    check("rs_pre_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_res_valid", 32'(ifc.res_valid), 32'd0);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_res_data", 32'(ifc.res_data), 32'h0000);
    tick();
    rst_n = 1'b1;
    ifc.res_ready = 1'b1;
    drive(1'b0, 1'b1, 16'hF00F, 4'd4, 2'b00);
    drive(1'b1, 1'b1, 16'h1111, 4'd0, 2'b00);
    #1;
    check("rs_prio_gnt0", 32'(ifc.req0_ready), 32'd1);
    check("rs_prio_gnt1", 32'(ifc.req1_ready), 32'd0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 4'h0, 2'b00);
    drive(1'b1, 1'b0, 16'h0, 4'h0, 2'b00);
    tick();
    check("rs_after_data", 32'(ifc.res_data), 32'hFF00);
    check("rs_after_id", 32'(ifc.res_id), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
